// File: rtl/scope_trace_renderer.sv
// Captures multi-channel samples into a row buffer (optionally triggered on ch0)
// and streams one full WIDTH x HEIGHT frame of graticule plus traces to the LCD driver.
module scope_trace_renderer #(
  parameter int          WIDTH         = 240,
  parameter int          HEIGHT        = 320,
  parameter int          SAMPLE_W      = 8,
  parameter int          CHANNELS      = 2,
  parameter int          GRID_DIV      = 40,
  parameter logic [63:0] TRACE_COLOURS = {16'hF81F, 16'h07FF, 16'hFFE0, 16'h07E0},
  parameter logic [15:0] GRID_COLOUR   = 16'h4208,
  parameter logic [15:0] BG_COLOUR     = 16'h0000,
  localparam int         X_BITS        = $clog2(WIDTH),
  localparam int         Y_BITS        = $clog2(HEIGHT)
) (
  input  logic                         clock,
  input  logic                         globalRst_n,
  input  logic                         sampleValid,
  input  logic [CHANNELS*SAMPLE_W-1:0] sampleData,
  input  logic [SAMPLE_W-1:0]          trigLevel,
  input  logic [1:0]                   trigMode,
  input  logic                         rearm,
  output logic [X_BITS-1:0]            xAddr,
  output logic [Y_BITS-1:0]            yAddr,
  output logic [15:0]                  pixelData,
  output logic                         pixelWrite,
  input  logic                         pixelReady,
  output logic                         armed,
  output logic                         frameDone
);

  typedef enum logic [2:0] {ARM, CAPTURE, LOAD, DRAW, STOP} state_t;

  state_t state, state_nxt;

  logic [CHANNELS*SAMPLE_W-1:0] frame_buf [HEIGHT];
  logic [CHANNELS*SAMPLE_W-1:0] row_samples;
  logic [Y_BITS-1:0]            wr_ptr;
  logic [SAMPLE_W-1:0]          prev_ch0;
  logic                         single_shot;
  logic [X_BITS-1:0]            x_mod;
  logic [Y_BITS-1:0]            y_mod;
  logic [X_BITS-1:0]            trace_col [CHANNELS];
  logic [15:0]                  pixel_colour;

  logic [SAMPLE_W-1:0] cur_ch0;
  logic                free_run, trig_hit, accept, last_col, last_row, capture_done;
  logic                buf_we;
  logic [Y_BITS-1:0]   buf_addr;

  assign cur_ch0      = sampleData[SAMPLE_W-1:0];
  assign free_run     = (trigMode == 2'd0) || (trigMode == 2'd3);
  assign trig_hit     = sampleValid && (free_run || ((prev_ch0 < trigLevel) && (cur_ch0 >= trigLevel)));
  assign accept       = (state == DRAW) && pixelReady;
  assign last_col     = (xAddr == X_BITS'(WIDTH - 1));
  assign last_row     = (yAddr == Y_BITS'(HEIGHT - 1));
  assign capture_done = (state == CAPTURE) && sampleValid && (wr_ptr == Y_BITS'(HEIGHT - 1));
  assign buf_we       = ((state == ARM) && trig_hit) || ((state == CAPTURE) && sampleValid);
  assign buf_addr     = (state == ARM) ? '0 : wr_ptr;

  always_ff @(posedge clock or negedge globalRst_n) begin
    if (!globalRst_n) state <= ARM;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pixelWrite = 1'b0;
    pixelData  = 16'h0000;
    case (state)
      ARM:     if (trig_hit) state_nxt = CAPTURE;
      CAPTURE: if (capture_done) state_nxt = LOAD;
      LOAD:    state_nxt = DRAW;
      DRAW: begin
        pixelWrite = 1'b1;
        pixelData  = pixel_colour;
        if (accept && last_col) begin
          if (!last_row)        state_nxt = LOAD;
          else if (single_shot) state_nxt = STOP;
          else                  state_nxt = ARM;
        end
      end
      STOP:    if (rearm) state_nxt = ARM;
      default: state_nxt = ARM;
    endcase
  end

  // Buffer has no reset; contents are only meaningful after a full capture.
  always_ff @(posedge clock) begin
    if (buf_we) frame_buf[buf_addr] <= sampleData;
    if (state == LOAD) row_samples <= frame_buf[yAddr];
  end

  always_ff @(posedge clock or negedge globalRst_n) begin
    if (!globalRst_n) begin
      xAddr       <= '0;
      yAddr       <= '0;
      x_mod       <= '0;
      y_mod       <= '0;
      wr_ptr      <= '0;
      prev_ch0    <= '1;
      single_shot <= 1'b0;
      armed       <= 1'b0;
      frameDone   <= 1'b0;
    end else begin
      armed     <= (state_nxt == ARM);
      frameDone <= accept && last_col && last_row;
      case (state)
        ARM: begin
          if (sampleValid) prev_ch0 <= cur_ch0;
          if (trig_hit) begin
            wr_ptr      <= Y_BITS'(1);
            single_shot <= (trigMode == 2'd2);
          end
        end
        CAPTURE: begin
          if (sampleValid) wr_ptr <= wr_ptr + Y_BITS'(1);
          if (capture_done) begin
            yAddr <= '0;
            y_mod <= '0;
          end
        end
        LOAD: begin
          xAddr <= '0;
          x_mod <= '0;
        end
        DRAW: begin
          // Graticule modulo is tracked by wrap counters alongside the addresses.
          if (accept && !last_col) begin
            xAddr <= xAddr + X_BITS'(1);
            x_mod <= (x_mod == X_BITS'(GRID_DIV - 1)) ? '0 : x_mod + X_BITS'(1);
          end else if (accept && !last_row) begin
            yAddr <= yAddr + Y_BITS'(1);
            y_mod <= (y_mod == Y_BITS'(GRID_DIV - 1)) ? '0 : y_mod + Y_BITS'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (int'(row_samples[c*SAMPLE_W + SAMPLE_W - 8 +: 8]) > WIDTH - 1)
        trace_col[c] = X_BITS'(WIDTH - 1);
      else
        trace_col[c] = X_BITS'(row_samples[c*SAMPLE_W + SAMPLE_W - 8 +: 8]);
    end
  end

  // Walk channels from highest to lowest so the lowest-index match wins.
  always_comb begin
    pixel_colour = (x_mod == '0 || y_mod == '0 || last_col || last_row) ? GRID_COLOUR : BG_COLOUR;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (trace_col[c] == xAddr) pixel_colour = TRACE_COLOURS[c*16 +: 16];
    end
  end

endmodule

// File: tb/tb_scope_trace_renderer.sv
// Self-checking bench for scope_trace_renderer: probe table, frame scoreboard against a
// row-based reference model, backpressure, single-shot, and asynchronous reset mid-draw.
module tb_scope_trace_renderer;

  localparam int W  = 240;
  localparam int H  = 12;
  localparam int GD = 8;
  localparam int CH = 2;
  localparam int SW = 8;
  localparam logic [63:0] TRACE = {16'hF81F, 16'h07FF, 16'hFFE0, 16'h07E0};
  localparam logic [15:0] GRID  = 16'h4208;
  localparam logic [15:0] BG    = 16'h0000;

  logic           clock = 1'b0;
  logic           globalRst_n;
  logic           sampleValid;
  logic [CH*SW-1:0] sampleData;
  logic [SW-1:0]  trigLevel;
  logic [1:0]     trigMode;
  logic           rearm;
  logic [7:0]     xAddr;
  logic [3:0]     yAddr;
  logic [15:0]    pixelData;
  logic           pixelWrite;
  logic           pixelReady;
  logic           armed;
  logic           frameDone;

  scope_trace_renderer #(
    .WIDTH(W), .HEIGHT(H), .SAMPLE_W(SW), .CHANNELS(CH), .GRID_DIV(GD),
    .TRACE_COLOURS(TRACE), .GRID_COLOUR(GRID), .BG_COLOUR(BG)
  ) dut (
    .clock(clock), .globalRst_n(globalRst_n), .sampleValid(sampleValid),
    .sampleData(sampleData), .trigLevel(trigLevel), .trigMode(trigMode),
    .rearm(rearm), .xAddr(xAddr), .yAddr(yAddr), .pixelData(pixelData),
    .pixelWrite(pixelWrite), .pixelReady(pixelReady), .armed(armed),
    .frameDone(frameDone)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          c0;
    int          c1;
    int          px;
    int          py;
    logic [15:0] expv;
  } vec_t;

  int          vectors = 0;
  int          miscompares = 0;
  int          mrow [H][CH];
  int          m_prev = 255;
  logic [15:0] got [H][W];
  logic [15:0] ref_frame [H][W];
  int          acc, ex, ey, fd;
  int          ready_mode = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference colour for a pixel, straight from the drawing rules.
  function automatic logic [15:0] exp_pix(input int x, input int y);
    for (int c = 0; c < CH; c++) begin
      int col;
      col = (mrow[y][c] > W - 1) ? W - 1 : mrow[y][c];
      if (col == x) return TRACE[c*16 +: 16];
    end
    if ((x % GD == 0) || (y % GD == 0) || (x == W - 1) || (y == H - 1)) return GRID;
    return BG;
  endfunction

  task automatic ready_loop();
    int phase = 0;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0:       pixelReady = 1'b1;
        1:       pixelReady = (phase == 2);
        default: pixelReady = 1'($urandom_range(1));
      endcase
      phase = (phase == 2) ? 0 : phase + 1;
    end
  endtask

  task automatic monitor_loop();
    logic        hold_v = 1'b0;
    logic [7:0]  hx = '0;
    logic [3:0]  hy = '0;
    logic [15:0] hd = '0;
    forever begin
      @(negedge clock);
      if (frameDone) begin
        fd++;
        checkOutput("frameDone_after_last_pixel", acc, W * H);
      end
      if (pixelWrite) begin
        if (hold_v) begin
          checkOutput("stall_xAddr", xAddr, hx);
          checkOutput("stall_yAddr", yAddr, hy);
          checkOutput("stall_pixelData", pixelData, hd);
        end
        if (pixelReady) begin
          checkOutput("scan_x", xAddr, ex);
          checkOutput("scan_y", yAddr, ey);
          if (int'(xAddr) < W && int'(yAddr) < H) begin
            checkOutput($sformatf("pixel(%0d,%0d)", xAddr, yAddr), pixelData, exp_pix(xAddr, yAddr));
            got[yAddr][xAddr] = pixelData;
          end else begin
            checkOutput("pixel_addr_in_range", 0, 1);
          end
          acc++;
          ex++;
          if (ex == W) begin
            ex = 0;
            ey++;
          end
          hold_v = 1'b0;
        end else begin
          hold_v = 1'b1;
          hx = xAddr;
          hy = yAddr;
          hd = pixelData;
        end
      end else begin
        hold_v = 1'b0;
      end
    end
  endtask

  // Drives samples and decides trigger/rows from the trigger rules alone.
  task automatic applyStimulus(input int mode, input int lvl, input int kind,
                               input int c0, input int c1, input int valid_pct);
    int  row = 0;
    bit  found = 0;
    bit  freerun;
    int  ramp_v = 0;
    int  s0, s1;
    trigMode  = 2'(mode);
    trigLevel = 8'(lvl);
    acc = 0; ex = 0; ey = 0; fd = 0;
    for (int n = 0; n < 100 && !armed; n++) @(negedge clock);
    checkOutput("armed_before_frame", armed, 1);
    freerun = (mode == 0) || (mode == 3);
    for (int n = 0; n < 3000 && row < H; n++) begin
      @(posedge clock);
      #1;
      if ($urandom_range(99) >= valid_pct) begin
        sampleValid = 1'b0;
        continue;
      end
      case (kind)
        0: begin s0 = c0; s1 = c1; end
        1: begin s0 = ramp_v; ramp_v = (ramp_v + 1) & 255; s1 = $urandom_range(255); end
        default: begin s0 = $urandom_range(255); s1 = $urandom_range(255); end
      endcase
      sampleValid = 1'b1;
      sampleData  = {8'(s1), 8'(s0)};
      if (!found) begin
        bit fire;
        fire   = freerun || (m_prev < lvl && s0 >= lvl);
        m_prev = s0;
        if (fire) begin
          found = 1;
          mrow[0][0] = s0;
          mrow[0][1] = s1;
          row = 1;
          @(negedge clock);
          checkOutput("armed_at_trigger_sample", armed, 1);
          @(posedge clock);
          #1 sampleValid = 1'b0;
          @(negedge clock);
          checkOutput("armed_after_trigger", armed, 0);
        end
      end else begin
        mrow[row][0] = s0;
        mrow[row][1] = s1;
        row++;
      end
    end
    @(posedge clock);
    #1 sampleValid = 1'b0;
    checkOutput("rows_captured", row, H);
  endtask

  task automatic wait_frame();
    for (int n = 0; n < 12000 && fd == 0; n++) @(negedge clock);
    repeat (5) @(negedge clock);
    checkOutput("frameDone_pulses", fd, 1);
    checkOutput("accepted_pixels", acc, W * H);
  endtask

  initial begin
    vec_t tbl [6];
    int   cnt;
    bit   hit;

    globalRst_n = 1'b1;
    sampleValid = 1'b0;
    sampleData  = '0;
    trigLevel   = '0;
    trigMode    = 2'd0;
    rearm       = 1'b0;
    pixelReady  = 1'b1;
    #1 globalRst_n = 1'b0;
    #2;
    checkOutput("reset_xAddr", xAddr, 0);
    checkOutput("reset_yAddr", yAddr, 0);
    checkOutput("reset_pixelData", pixelData, 0);
    checkOutput("reset_pixelWrite", pixelWrite, 0);
    checkOutput("reset_armed", armed, 0);
    checkOutput("reset_frameDone", frameDone, 0);
    fork
      ready_loop();
      monitor_loop();
    join_none
    repeat (2) @(posedge clock);
    #1 globalRst_n = 1'b1;

    tbl[0] = '{64, 128, 64, 7, 16'h07E0};
    tbl[1] = '{64, 128, 128, 7, 16'hFFE0};
    tbl[2] = '{64, 128, 0, 0, 16'h4208};
    tbl[3] = '{64, 128, 1, 1, 16'h0000};
    tbl[4] = '{255, 255, 239, 0, 16'h07E0};
    tbl[5] = '{255, 255, 239, 6, 16'h07E0};
    for (int i = 0; i < 6; i++) begin
      if (i == 0 || tbl[i].c0 != tbl[i-1].c0 || tbl[i].c1 != tbl[i-1].c1) begin
        ready_mode = 0;
        applyStimulus(0, 0, 0, tbl[i].c0, tbl[i].c1, 100);
        wait_frame();
        if (tbl[i].c0 == 64) ref_frame = got;
      end
      checkOutput($sformatf("probe(%0d,%0d)", tbl[i].px, tbl[i].py),
                  got[tbl[i].py][tbl[i].px], tbl[i].expv);
    end
    cnt = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (got[y][x] == 16'hFFE0) cnt++;
    checkOutput("overlap_ch1_pixels", cnt, 0);

    $display("[TB] backpressure frame");
    ready_mode = 1;
    applyStimulus(0, 0, 0, 64, 128, 100);
    wait_frame();
    cnt = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (got[y][x] != ref_frame[y][x]) cnt++;
    checkOutput("backpressure_frame_diffs", cnt, 0);

    $display("[TB] normal-mode ramp");
    ready_mode = 0;
    applyStimulus(1, 128, 1, 0, 0, 100);
    wait_frame();
    checkOutput("ramp_row0_col128", got[0][128], 16'h07E0);
    checkOutput("ramp_row1_col129", got[1][129], 16'h07E0);

    $display("[TB] random frames");
    for (int i = 0; i < 3; i++) begin
      int pick;
      pick = $urandom_range(2);
      ready_mode = 2;
      applyStimulus((pick == 0) ? 0 : (pick == 1) ? 1 : 3, $urandom_range(240, 16), 2, 0, 0, 75);
      wait_frame();
    end

    $display("[TB] single-shot");
    ready_mode = 0;
    applyStimulus(2, 100, 1, 0, 0, 100);
    wait_frame();
    checkOutput("single_armed_after_done", armed, 0);
    cnt = 0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clock);
      #1;
      sampleValid = 1'b1;
      sampleData  = {8'(n * 7), 8'(n)};
      @(negedge clock);
      if (pixelWrite || armed) cnt++;
    end
    @(posedge clock);
    #1 sampleValid = 1'b0;
    checkOutput("stop_ignores_crossings", cnt, 0);
    rearm = 1'b1;
    @(negedge clock);
    checkOutput("armed_before_rearm_edge", armed, 0);
    @(posedge clock);
    #1 rearm = 1'b0;
    @(negedge clock);
    checkOutput("armed_after_rearm", armed, 1);

    $display("[TB] reset during draw");
    applyStimulus(0, 0, 2, 0, 0, 100);
    hit = 0;
    for (int n = 0; n < 5000 && !hit; n++) begin
      @(negedge clock);
      hit = pixelWrite && xAddr == 8'd100 && yAddr == 4'd5;
    end
    checkOutput("reached_pixel_100_5", hit, 1);
    #2 globalRst_n = 1'b0;
    #1;
    m_prev = 255;
    checkOutput("midreset_xAddr", xAddr, 0);
    checkOutput("midreset_yAddr", yAddr, 0);
    checkOutput("midreset_pixelData", pixelData, 0);
    checkOutput("midreset_pixelWrite", pixelWrite, 0);
    checkOutput("midreset_armed", armed, 0);
    checkOutput("midreset_frameDone", frameDone, 0);
    repeat (2) @(posedge clock);
    #1 globalRst_n = 1'b1;
    trigMode = 2'd1;
    cnt = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clock);
      if (pixelWrite) cnt++;
    end
    checkOutput("no_draw_after_reset", cnt, 0);
    checkOutput("armed_after_reset", armed, 1);
    applyStimulus(1, 128, 1, 0, 0, 100);
    wait_frame();
    checkOutput("post_reset_row0_col128", got[0][128], 16'h07E0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
